// File: rtl/prog_loader_pkg.sv
// Shared constants for the program loader: memory geometry, header encoding and FSM state encoding.
package prog_loader_pkg;

    localparam int PROG_ADDR_W = 4;
    localparam int PROG_DATA_W = 8;
    localparam int PROG_DEPTH  = 1 << PROG_ADDR_W;

    // A zero header byte requests a full-depth load.
    localparam logic [PROG_DATA_W-1:0] HDR_LEN_FULL = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } ld_state_t;

endpackage

// File: rtl/prog_loader_ld_sum8.sv
// ld_sum8: 8-bit checksum register with synchronous clear and accumulate (sum wraps mod 256).
module ld_sum8 (
    input  logic       clk,
    input  logic       clr,
    input  logic       clear,
    input  logic       acc_en,
    input  logic [7:0] din,
    output logic [7:0] sum
);

    always_ff @(posedge clk) begin
        if (!clr) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (acc_en) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: writes a length-prefixed byte stream into the 16x8 program RAM and holds the CPU until done.
// Build option: define PROG_LOADER_CHKSUM_EN to require a trailing mod-256 checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = PROG_ADDR_W,
    parameter int DATA_W = PROG_DATA_W,
    parameter int DEPTH  = PROG_DEPTH
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [DATA_W-1:0] DEPTH_BYTE = DATA_W'(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_CNT  = (ADDR_W+1)'(DEPTH);

    ld_state_t         state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   length;
    logic [ADDR_W:0]   hdr_len;
    logic [ADDR_W:0]   count_nxt;
    logic              hdr_bad;
    logic              accept;
    logic              start_load;

    // NOTE: in_ready decodes the state register only, so the handshake never forms a loop through in_valid.
    assign in_ready   = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CHK);
    assign accept     = in_valid && in_ready;
    assign start_load = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign count_nxt  = count + 1'b1;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        hdr_len = in_data[ADDR_W:0];
        hdr_bad = 1'b0;
        if (in_data == HDR_LEN_FULL) begin
            hdr_len = DEPTH_CNT;
        end else if (in_data > DEPTH_BYTE) begin
            hdr_bad = 1'b1;
        end
    end

`ifdef PROG_LOADER_CHKSUM_EN
    logic [7:0] sum;

    ld_sum8 u_sum (
        .clk    (clk),
        .clr    (clr),
        .clear  (start_load),
        .acc_en (accept && (state == ST_DATA)),
        .din    (in_data),
        .sum    (sum)
    );
`endif

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= ST_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            count     <= '0;
            length    <= '0;
            ptr       <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_load) begin
                        state    <= ST_HDR;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        count    <= '0;
                        cpu_hold <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (accept) begin
                        if (hdr_bad) begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end else begin
                            state  <= ST_DATA;
                            length <= hdr_len;
                            ptr    <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr;
                        mem_wdata <= in_data;
                        ptr       <= ptr + 1'b1;
                        count     <= count_nxt;
                        if (count_nxt == length) begin
`ifdef PROG_LOADER_CHKSUM_EN
                            state <= ST_CHK;
`else
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end
                    end
                end
`ifdef PROG_LOADER_CHKSUM_EN
                ST_CHK: begin
                    if (accept) begin
                        if (in_data == sum) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed loads plus randomized loads against a behavioural model.
// Honours PROG_LOADER_CHKSUM_EN when the design is built with the checksum option.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int AW = PROG_ADDR_W;
    localparam int DW = PROG_DATA_W;
    localparam int N  = PROG_DEPTH;

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;
    logic [AW:0]   count;

    logic [7:0] tb_ram  [N] = '{default: 8'h00};
    logic [7:0] exp_ram [N] = '{default: 8'h00};
    logic [7:0] pay     [N];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    // Program RAM as seen by the CPU: captures whatever the loader writes.
    always @(posedge clk) begin
        if (mem_we === 1'b1) tb_ram[mem_addr] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  in_ready,  0);
        check({tag, "_mem_we"},    mem_we,    0);
        check({tag, "_mem_addr"},  mem_addr,  0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_cpu_hold"},  cpu_hold,  1);
        check({tag, "_done"},      done,      0);
        check({tag, "_err"},       err,       0);
        check({tag, "_count"},     count,     0);
    endtask

    task automatic ram_compare(input string tag);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_ram[%0d]", tag, i), tb_ram[i], exp_ram[i]);
    endtask

    // Presents one byte after up to max_stall idle cycles; start is toggled randomly when stalls are enabled.
    task automatic send(input logic [7:0] b, input int max_stall);
        int gap;
        bit acc;
        gap = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
        for (int k = 0; k < gap; k++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            start    = 1'($urandom_range(1, 0));
            step();
            check("stall_no_write", mem_we, 0);
        end
        in_valid = 1'b1;
        in_data  = b;
        start    = (max_stall > 0) ? 1'($urandom_range(1, 0)) : 1'b0;
        acc      = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = in_ready;
            step();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic expect_done(input string tag, input int len);
        check({tag, "_done"},     done,     1);
        check({tag, "_err"},      err,      0);
        check({tag, "_cpu_hold"}, cpu_hold, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_count"},    count,    len);
    endtask

    task automatic expect_err(input string tag);
        check({tag, "_err"},      err,      1);
        check({tag, "_done"},     done,     0);
        check({tag, "_cpu_hold"}, cpu_hold, 1);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    // One complete load: start pulse, header, payload from pay[], optional checksum byte.
    task automatic run_load(input string tag, input logic [7:0] hdr, input int max_stall, input bit chk_ok);
        int         len;
        bit         bad;
        logic [7:0] sum;
        bad = (hdr > 8'd16);
        len = (hdr == 8'd0) ? N : int'(hdr);
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_hdr_ready"}, in_ready, 1);
        check({tag, "_start_done"}, done, 0);
        check({tag, "_start_err"}, err, 0);
        check({tag, "_start_count"}, count, 0);
        check({tag, "_start_hold"}, cpu_hold, 1);
        send(hdr, max_stall);
        if (bad) begin
            expect_err({tag, "_badhdr"});
            check({tag, "_badhdr_we"}, mem_we, 0);
            step();
            check({tag, "_badhdr_we2"}, mem_we, 0);
            ram_compare(tag);
            return;
        end
        check({tag, "_hdr_no_write"}, mem_we, 0);
        sum = 8'h00;
        for (int i = 0; i < len; i++) begin
            send(pay[i], max_stall);
            check({tag, "_wr_we"},    mem_we,    1);
            check({tag, "_wr_addr"},  mem_addr,  i);
            check({tag, "_wr_data"},  mem_wdata, pay[i]);
            check({tag, "_wr_count"}, count,     i + 1);
            exp_ram[i] = pay[i];
            sum = sum + pay[i];
            if (i < len - 1) check({tag, "_done_early"}, done, 0);
        end
`ifdef PROG_LOADER_CHKSUM_EN
        check({tag, "_chk_ready"}, in_ready, 1);
        check({tag, "_chk_done"},  done,     0);
        send(chk_ok ? sum : sum + 8'd1, max_stall);
        check({tag, "_chk_no_write"}, mem_we, 0);
        if (chk_ok) expect_done(tag, len);
        else        expect_err(tag);
`else
        expect_done(tag, len);
`endif
        step();
        check({tag, "_no_extra_write"}, mem_we, 0);
        ram_compare(tag);
    endtask

    initial begin
        clr      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        step();
        step();
        check_reset_outputs("reset");
        clr = 1'b1;
        step();
        check_reset_outputs("idle");

        // Basic three-byte load with valid held high.
        pay[0] = 8'h1A; pay[1] = 8'h2B; pay[2] = 8'hE0;
        run_load("basic", 8'd3, 0, 1'b1);

        // Full-depth load: header 0, data equals address.
        for (int i = 0; i < N; i++) pay[i] = 8'(i);
        run_load("full", 8'h00, 0, 1'b1);

        // Bad header aborts; a following load must still work.
        run_load("bad", 8'h11, 0, 1'b1);
        for (int i = 0; i < N; i++) pay[i] = 8'($urandom);
        run_load("after_bad", 8'd5, 0, 1'b1);

        // Backpressure (valid 1,0,0,1) then reset after two data bytes.
        for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
        start = 1'b1;
        step();
        start = 1'b0;
        send(8'd4, 0);
        send(pay[0], 0);
        check("bp_wr0_we", mem_we, 1);
        check("bp_wr0_addr", mem_addr, 0);
        check("bp_wr0_data", mem_wdata, pay[0]);
        exp_ram[0] = pay[0];
        step();
        check("bp_stall1", mem_we, 0);
        step();
        check("bp_stall2", mem_we, 0);
        send(pay[1], 0);
        check("bp_wr1_we", mem_we, 1);
        check("bp_wr1_addr", mem_addr, 1);
        check("bp_wr1_data", mem_wdata, pay[1]);
        exp_ram[1] = pay[1];
        in_valid = 1'b1;
        in_data  = pay[2];
        clr      = 1'b0;
        step();
        in_valid = 1'b0;
        check_reset_outputs("midload_rst");
        clr = 1'b1;
        step();
        check("midload_no_write", mem_we, 0);
        ram_compare("midload");

`ifdef PROG_LOADER_CHKSUM_EN
        pay[0] = 8'hF0; pay[1] = 8'h20;
        run_load("chk_good", 8'd2, 0, 1'b1);
        run_load("chk_bad", 8'd2, 0, 1'b0);
`endif

        // Randomized loads: stalls, ignored start pulses, occasional bad headers/checksums.
        for (int t = 0; t < 30; t++) begin
            logic [7:0] hdr;
            if ($urandom_range(3, 0) == 0) hdr = 8'($urandom_range(255, 17));
            else                            hdr = 8'($urandom_range(16, 0));
            for (int i = 0; i < N; i++) pay[i] = 8'($urandom);
            run_load($sformatf("rand%0d", t), hdr, 3, ($urandom_range(3, 0) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
